snax_hwpe_tcdm_bridge: RTL and testbench

SNAX_HWPE_TCDM_BRIDGE -- requirements
Module: snax_hwpe_tcdm_bridge

---
 rtl/snax_hwpe_tcdm_bridge_pkg.sv | 64 ++++++
 rtl/hwpe_stream_intf_tcdm.sv | 16 +
 rtl/snax_hwpe_tcdm_bridge_fifo.sv | 54 +++++
 rtl/snax_hwpe_tcdm_bridge.sv | 152 +++++++++++++++
 tb/tb_snax_hwpe_tcdm_bridge.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snax_hwpe_tcdm_bridge_pkg.sv
// Shared types for the HWPE-to-reqrsp TCDM bridge: queue entries, default reqrsp payloads
// and the lane-index width helper.
package snax_hwpe_bridge_pkg;

  localparam int unsigned MaxLaneIdxWidth = 3;

  typedef enum logic [3:0] {
    AMONone = 4'h0,
    AMOSwap = 4'h1,
    AMOAdd  = 4'h2,
    AMOAnd  = 4'h3,
    AMOOr   = 4'h4,
    AMOXor  = 4'h5,
    AMOMax  = 4'h6,
    AMOMaxu = 4'h7,
    AMOMin  = 4'h8,
    AMOMinu = 4'h9,
    AMOLR   = 4'hA,
    AMOSC   = 4'hB
  } amo_op_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  be;
    logic [31:0] data;
  } hwpe_req_entry_t;

  // Lane is stored at the widest legal size so one type serves every data width.
  typedef struct packed {
    logic                       is_read;
    logic [MaxLaneIdxWidth-1:0] lane;
  } meta_entry_t;

  function automatic int unsigned lane_idx_width(input int unsigned mem_data_width);
    return (mem_data_width > 32) ? $clog2(mem_data_width / 32) : 1;
  endfunction

  typedef struct packed {
    logic [47:0] addr;
    logic        write;
    amo_op_e     amo;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [0:0]  user;
  } tcdm_req_chan_t;

  typedef struct packed {
    tcdm_req_chan_t q;
    logic           q_valid;
    logic           p_ready;
  } tcdm_req_default_t;

  typedef struct packed {
    logic [63:0] data;
  } tcdm_rsp_chan_t;

  typedef struct packed {
    logic           q_ready;
    tcdm_rsp_chan_t p;
    logic           p_valid;
  } tcdm_rsp_default_t;

endpackage

// File: rtl/hwpe_stream_intf_tcdm.sv
// 32-bit HWPE TCDM port: single-cycle grant on the request side, r_valid/r_data on the way back.
interface hwpe_stream_intf_tcdm;

  logic        req;
  logic        gnt;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] data;
  logic [31:0] r_data;
  logic        r_valid;

  modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
  modport slave (input req, add, wen, be, data, output gnt, r_data, r_valid);

endinterface

// File: rtl/snax_hwpe_tcdm_bridge_fifo.sv
// common_cells-compatible fifo_v3 (registered output, no fall-through) used for both bridge queues.
module fifo_v3 #(
  parameter int unsigned DEPTH = 8,
  parameter type dtype = logic [31:0]
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic full_o,
  output logic empty_o,
  input  dtype data_i,
  input  logic push_i,
  output dtype data_o,
  input  logic pop_i
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  dtype             mem [DEPTH];
  logic [AddrW-1:0] rd_ptr;
  logic [AddrW-1:0] wr_ptr;
  logic [CntW-1:0]  count;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count == CntW'(DEPTH));
  assign empty_o = (count == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == AddrW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == AddrW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      count <= count + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= data_i;
    end
  end

endmodule

// File: rtl/snax_hwpe_tcdm_bridge.sv
// Bridges a 32-bit HWPE TCDM port onto a wide reqrsp TCDM port with in-order response matching.
// Define SNAX_HWPE_TCDM_BRIDGE_STATS_EN to build the read/write/stall performance counters.
module snax_hwpe_tcdm_bridge
  import snax_hwpe_bridge_pkg::*;
#(
  parameter int unsigned AddrWidth      = 48,
  parameter int unsigned MemDataWidth   = 64,
  parameter int unsigned ReqFifoDepth   = 8,
  parameter int unsigned MaxOutstanding = 4,
  parameter type tcdm_req_t = tcdm_req_default_t,
  parameter type tcdm_rsp_t = tcdm_rsp_default_t
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  output tcdm_req_t                  tcdm_req_o,
  input  tcdm_rsp_t                  tcdm_rsp_i,
  hwpe_stream_intf_tcdm.slave        hwpe_tcdm_slave,
  output logic                       busy_o,
  output logic [31:0]                stat_reads_o,
  output logic [31:0]                stat_writes_o,
  output logic [31:0]                stat_stall_o
);

  localparam int unsigned LaneW = lane_idx_width(MemDataWidth);
  localparam int unsigned StrbW = MemDataWidth / 8;
  localparam int unsigned OutW  = $clog2(MaxOutstanding + 1);

  hwpe_req_entry_t  push_entry;
  hwpe_req_entry_t  head;
  meta_entry_t      meta_push;
  meta_entry_t      meta_head;
  logic             req_full;
  logic             req_empty;
  logic             meta_full;
  logic             meta_empty;
  logic             push;
  logic             issue;
  logic             resp;
  logic             q_valid;
  logic [LaneW-1:0] lane;
  logic [OutW-1:0]  outstanding;

  assign push                = hwpe_tcdm_slave.req & ~req_full;
  assign hwpe_tcdm_slave.gnt = push;
  // HWPE wen is active-low write enable, so it is inverted into a write flag on entry.
  assign push_entry = '{
    addr:  hwpe_tcdm_slave.add,
    write: ~hwpe_tcdm_slave.wen,
    be:    hwpe_tcdm_slave.be,
    data:  hwpe_tcdm_slave.data
  };

  fifo_v3 #(
    .DEPTH (ReqFifoDepth),
    .dtype (hwpe_req_entry_t)
  ) i_req_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .full_o  (req_full),
    .empty_o (req_empty),
    .data_i  (push_entry),
    .push_i  (push),
    .data_o  (head),
    .pop_i   (issue)
  );

  assign lane      = head.addr[LaneW+1:2];
  assign q_valid   = ~req_empty & (outstanding < OutW'(MaxOutstanding));
  assign issue     = q_valid & tcdm_rsp_i.q_ready;
  assign meta_push = '{is_read: ~head.write, lane: MaxLaneIdxWidth'(lane)};

  always_comb begin
    tcdm_req_o         = '0;
    tcdm_req_o.q.addr  = AddrWidth'(head.addr);
    tcdm_req_o.q.write = head.write;
    tcdm_req_o.q.amo   = AMONone;
    tcdm_req_o.q.data  = MemDataWidth'(head.data) << {lane, 5'b0};
    tcdm_req_o.q.strb  = StrbW'(head.be) << {lane, 2'b0};
    tcdm_req_o.q_valid = q_valid;
    tcdm_req_o.p_ready = 1'b1;
  end

  fifo_v3 #(
    .DEPTH (MaxOutstanding),
    .dtype (meta_entry_t)
  ) i_meta_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .full_o  (meta_full),
    .empty_o (meta_empty),
    .data_i  (meta_push),
    .push_i  (issue),
    .data_o  (meta_head),
    .pop_i   (resp)
  );

  // A response with nothing outstanding is dropped so the counter can never underflow.
  assign resp                    = tcdm_rsp_i.p_valid & ~meta_empty;
  assign hwpe_tcdm_slave.r_valid = resp & meta_head.is_read;
  assign hwpe_tcdm_slave.r_data  = 32'(tcdm_rsp_i.p.data >> {meta_head.lane, 5'b0});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding <= '0;
    end else if (issue != resp) begin
      outstanding <= issue ? outstanding + 1'b1 : outstanding - 1'b1;
    end
  end

  assign busy_o = ~req_empty | (outstanding != '0);

`ifdef SNAX_HWPE_TCDM_BRIDGE_STATS_EN
  logic [31:0] reads;
  logic [31:0] writes;
  logic [31:0] stalls;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reads  <= '0;
      writes <= '0;
      stalls <= '0;
    end else begin
      if (issue && head.write) begin
        writes <= writes + 32'd1;
      end
      if (issue && !head.write) begin
        reads <= reads + 32'd1;
      end
      if (hwpe_tcdm_slave.req && req_full) begin
        stalls <= stalls + 32'd1;
      end
    end
  end

  assign stat_reads_o  = reads;
  assign stat_writes_o = writes;
  assign stat_stall_o  = stalls;
`else
  assign stat_reads_o  = '0;
  assign stat_writes_o = '0;
  assign stat_stall_o  = '0;
`endif

  stray_response: assert property (@(posedge clk_i) disable iff (!rst_ni)
    tcdm_rsp_i.p_valid |-> !meta_empty)
    else $warning("snax_hwpe_tcdm_bridge: response received with no request outstanding");

  meta_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    issue |-> !meta_full)
    else $error("snax_hwpe_tcdm_bridge: meta FIFO overflow");

endmodule

// File: tb/tb_snax_hwpe_tcdm_bridge.sv
// Randomized and directed bench for snax_hwpe_tcdm_bridge against a queue/memory reference model.
module tb_snax_hwpe_tcdm_bridge;
  import snax_hwpe_bridge_pkg::*;

`ifdef SNAX_HWPE_TCDM_BRIDGE_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  be;
    logic [31:0] data;
  } hreq_t;

  typedef struct {
    logic        is_read;
    logic        lane;
    logic [63:0] word;
  } pend_t;

  logic              clk = 1'b0;
  logic              rst_n;
  tcdm_req_default_t tcdm_req;
  tcdm_rsp_default_t tcdm_rsp;
  logic              busy;
  logic [31:0]       stat_reads;
  logic [31:0]       stat_writes;
  logic [31:0]       stat_stall;

  hwpe_stream_intf_tcdm hwpe ();

  always #5 clk = ~clk;

  snax_hwpe_tcdm_bridge dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .tcdm_req_o      (tcdm_req),
    .tcdm_rsp_i      (tcdm_rsp),
    .hwpe_tcdm_slave (hwpe),
    .busy_o          (busy),
    .stat_reads_o    (stat_reads),
    .stat_writes_o   (stat_writes),
    .stat_stall_o    (stat_stall)
  );

  hreq_t       req_q[$];
  pend_t       out_q[$];
  logic [63:0] mem [int unsigned];
  logic [31:0] rdata_log[$];
  int          passed = 0;
  int          total = 0;
  int          model_reads, model_writes, model_stall;
  int          gnt_seen, rvalid_seen, issue_seen;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] mem_read(input logic [31:0] addr);
    int unsigned idx = addr >> 3;
    if (mem.exists(idx)) return mem[idx];
    return {idx ^ 32'hC0FF_EE00, ~idx};
  endfunction

  function automatic logic [63:0] exp_qdata(input hreq_t h);
    logic [31:0] lanes [2];
    lanes[0] = '0;
    lanes[1] = '0;
    lanes[h.addr[2]] = h.data;
    return {lanes[1], lanes[0]};
  endfunction

  function automatic logic [7:0] exp_strb(input hreq_t h);
    logic [3:0] lanes [2];
    lanes[0] = '0;
    lanes[1] = '0;
    lanes[h.addr[2]] = h.be;
    return {lanes[1], lanes[0]};
  endfunction

  // The bench plays the memory: reads sample and writes update it in issue order.
  task automatic model_issue();
    hreq_t       h = req_q.pop_front();
    pend_t       p;
    logic [63:0] word = mem_read(h.addr);
    int          lane = int'(h.addr[2]);
    p.is_read = !h.write;
    p.lane    = h.addr[2];
    p.word    = word;
    if (h.write) begin
      for (int b = 0; b < 4; b++)
        if (h.be[b]) word[32*lane + 8*b +: 8] = h.data[8*b +: 8];
      mem[h.addr >> 3] = word;
      p.word = {$urandom, $urandom};
      model_writes++;
    end else begin
      model_reads++;
    end
    out_q.push_back(p);
  endtask

  task automatic applyStimulus(input logic req, input logic wen, input logic [31:0] addr,
                               input logic [3:0] be, input logic [31:0] data,
                               input logic q_ready, input logic rsp_en);
    logic exp_gnt, exp_qv, exp_rv, pv;
    hwpe.req  = req;
    hwpe.wen  = wen;
    hwpe.add  = addr;
    hwpe.be   = be;
    hwpe.data = data;
    tcdm_rsp.q_ready = q_ready;
    pv = rsp_en && (out_q.size() > 0);
    tcdm_rsp.p_valid = pv;
    tcdm_rsp.p.data  = pv ? out_q[0].word : {$urandom, $urandom};
    #1;
    exp_gnt = req && (req_q.size() < 8);
    exp_qv  = (req_q.size() > 0) && (out_q.size() < 4);
    exp_rv  = 1'b0;
    if (pv) exp_rv = out_q[0].is_read;
    checkOutput("gnt", hwpe.gnt, exp_gnt);
    checkOutput("q_valid", tcdm_req.q_valid, exp_qv);
    checkOutput("r_valid", hwpe.r_valid, exp_rv);
    checkOutput("busy", busy, (req_q.size() > 0) || (out_q.size() > 0));
    checkOutput("p_ready", tcdm_req.p_ready, 1'b1);
    if (exp_qv) begin
      checkOutput("q_addr", tcdm_req.q.addr, {16'b0, req_q[0].addr});
      checkOutput("q_write", tcdm_req.q.write, req_q[0].write);
      checkOutput("q_data", tcdm_req.q.data, exp_qdata(req_q[0]));
      checkOutput("q_strb", tcdm_req.q.strb, exp_strb(req_q[0]));
      checkOutput("q_amo", tcdm_req.q.amo, AMONone);
    end
    if (exp_rv)
      checkOutput("r_data", hwpe.r_data,
                  out_q[0].lane ? out_q[0].word[63:32] : out_q[0].word[31:0]);
    if (hwpe.gnt) gnt_seen++;
    if (hwpe.r_valid) begin
      rvalid_seen++;
      rdata_log.push_back(hwpe.r_data);
    end
    if (tcdm_req.q_valid && q_ready) issue_seen++;
    @(posedge clk);
    if (pv) void'(out_q.pop_front());
    if (exp_qv && q_ready) model_issue();
    if (req && !exp_gnt) model_stall++;
    if (exp_gnt) req_q.push_back('{addr: addr, write: !wen, be: be, data: data});
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic q_ready, input logic rsp_en);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, '0, '0, '0, q_ready, rsp_en);
  endtask

  task automatic check_stats(input string tag);
    checkOutput({tag, "_reads"}, stat_reads, StatsOn ? model_reads : 0);
    checkOutput({tag, "_writes"}, stat_writes, StatsOn ? model_writes : 0);
    checkOutput({tag, "_stall"}, stat_stall, StatsOn ? model_stall : 0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    hwpe.req = 1'b1;
    tcdm_rsp = '0;
    #1;
    checkOutput({tag, "_q_valid"}, tcdm_req.q_valid, 1'b0);
    checkOutput({tag, "_r_valid"}, hwpe.r_valid, 1'b0);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_gnt"}, hwpe.gnt, 1'b1);
    checkOutput({tag, "_stat_reads"}, stat_reads, 32'd0);
    checkOutput({tag, "_stat_writes"}, stat_writes, 32'd0);
    checkOutput({tag, "_stat_stall"}, stat_stall, 32'd0);
    repeat (2) @(negedge clk);
    hwpe.req = 1'b0;
    req_q.delete();
    out_q.delete();
    model_reads = 0;
    model_writes = 0;
    model_stall = 0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1;
    tcdm_rsp = '0;
    hwpe.req = 1'b0;
    hwpe.wen = 1'b1;
    hwpe.add = '0;
    hwpe.be = '0;
    hwpe.data = '0;
    @(negedge clk);
    do_reset("reset");

    $display("[TB] single write lane placement");
    applyStimulus(1'b1, 1'b0, 32'h1000_0004, 4'b0011, 32'hDEAD_BEEF, 1'b1, 1'b1);
    #1;
    checkOutput("wr_lane1_data", tcdm_req.q.data, 64'hDEAD_BEEF_0000_0000);
    checkOutput("wr_lane1_strb", tcdm_req.q.strb, 8'b0011_0000);
    checkOutput("wr_lane1_write", tcdm_req.q.write, 1'b1);
    idle(3, 1'b1, 1'b1);

    $display("[TB] two reads of one memory word");
    mem[32'h1000_0008 >> 3] = 64'hFEED5678_C0DEBABE;
    rdata_log.delete();
    applyStimulus(1'b1, 1'b1, 32'h1000_0008, 4'hF, '0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h1000_000C, 4'hF, '0, 1'b1, 1'b0);
    idle(2, 1'b1, 1'b0);
    idle(3, 1'b1, 1'b1);
    checkOutput("rd_count", rdata_log.size(), 2);
    if (rdata_log.size() == 2) begin
      checkOutput("rd_first", rdata_log[0], 32'hC0DE_BABE);
      checkOutput("rd_second", rdata_log[1], 32'hFEED_5678);
    end

    $display("[TB] write/read/write interleave");
    rvalid_seen = 0;
    applyStimulus(1'b1, 1'b0, 32'h1000_0010, 4'hF, 32'h1111_2222, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h1000_0014, 4'hF, '0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h1000_0018, 4'h5, 32'h3333_4444, 1'b1, 1'b1);
    idle(6, 1'b1, 1'b1);
    checkOutput("interleave_rvalids", rvalid_seen, 1);
    checkOutput("interleave_busy", busy, 1'b0);

    $display("[TB] back-pressure fills the request FIFO");
    do_reset("reset2");
    gnt_seen = 0;
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 32'h2000_0000 + 32'(i * 4),
                    4'($urandom_range(0, 15)), $urandom, 1'b0, 1'b0);
    checkOutput("bp_grants", gnt_seen, 8);
    checkOutput("bp_stall", stat_stall, StatsOn ? 32'd12 : 32'd0);
    check_stats("bp");

    $display("[TB] outstanding limit");
    issue_seen = 0;
    idle(6, 1'b1, 1'b0);
    checkOutput("limit_issues", issue_seen, 4);
    #1;
    checkOutput("limit_qv_low", tcdm_req.q_valid, 1'b0);
    applyStimulus(1'b0, 1'b1, '0, '0, '0, 1'b0, 1'b1);
    #1;
    checkOutput("limit_qv_reopen", tcdm_req.q_valid, 1'b1);
    idle(20, 1'b1, 1'b1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                    32'h2000_0000 + 32'($urandom_range(0, 15)) * 4,
                    4'($urandom_range(0, 15)), $urandom,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    idle(30, 1'b1, 1'b1);
    checkOutput("drain_busy", busy, 1'b0);
    check_stats("rand");

    $display("[TB] reset with reads outstanding");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b1, 32'h3000_0000 + 32'(i * 4), 4'hF, '0, 1'b1, 1'b0);
    idle(1, 1'b1, 1'b0);
    checkOutput("pre_reset_outstanding", out_q.size(), 3);
    do_reset("midreset");
    tcdm_rsp.p_valid = 1'b1;
    tcdm_rsp.p.data = 64'h0123_4567_89AB_CDEF;
    #1;
    checkOutput("stray_rvalid", hwpe.r_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    tcdm_rsp.p_valid = 1'b0;
    #1;
    checkOutput("stray_busy", busy, 1'b0);
    checkOutput("stray_qv", tcdm_req.q_valid, 1'b0);
    @(negedge clk);
    idle(2, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
